// File: rtl/mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_arbiter                                                  |
// | Description : Two-requester round-robin arbiter that owns a 2:1 mux select |
// |               and registers the selected data; optional MUX_ARBITER_LOCK_EN |
// |               adds a lock input that suppresses forced rotation.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUX_ARBITER_LOCK_EN
    input  logic             lock,
`endif
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] x,
    output logic             x_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_A = 2'd1;
    localparam logic [1:0] S_OWN_B = 2'd2;

    localparam logic [7:0] c_last_cnt = 8'(MAX_BURST - 1);

    logic [1:0]       r_state;
    logic             r_last_owner;   // 0 = A, 1 = B
    logic [7:0]       r_burst_cnt;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_sel;
    logic [WIDTH-1:0] r_x;
    logic             r_x_valid;

    logic [1:0]       w_next;
    logic [7:0]       w_cnt_next;
    logic [7:0]       w_cnt_inc;
    logic             w_entry;
    logic             w_lock;

`ifdef MUX_ARBITER_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_cnt_inc = (r_burst_cnt == c_last_cnt) ? r_burst_cnt : r_burst_cnt + 8'd1;

    // The counter only advances on contended cycles; an uncontended owner keeps it at zero.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_a && req_b) begin
                    w_next = r_last_owner ? S_OWN_A : S_OWN_B;
                end else if (req_a) begin
                    w_next = S_OWN_A;
                end else if (req_b) begin
                    w_next = S_OWN_B;
                end
            end
            S_OWN_A: begin
                if (!req_a) begin
                    w_next = req_b ? S_OWN_B : S_IDLE;
                end else if (req_b) begin
                    if ((r_burst_cnt == c_last_cnt) && !w_lock) begin
                        w_next = S_OWN_B;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_cnt_next = 8'd0;
                end
            end
            S_OWN_B: begin
                if (!req_b) begin
                    w_next = req_a ? S_OWN_A : S_IDLE;
                end else if (req_a) begin
                    if ((r_burst_cnt == c_last_cnt) && !w_lock) begin
                        w_next = S_OWN_A;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_cnt_next = 8'd0;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = 8'd0;
            end
        endcase
        w_entry = (w_next != r_state) && (w_next != S_IDLE);
        if (w_entry) begin
            w_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= 8'd0;
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_sel        <= 1'b0;
            r_x          <= '0;
            r_x_valid    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_burst_cnt <= w_cnt_next;
            r_gnt_a     <= (w_next == S_OWN_A);
            r_gnt_b     <= (w_next == S_OWN_B);
            r_sel       <= (w_next == S_OWN_B);
            if (w_entry) begin
                r_last_owner <= (w_next == S_OWN_B);
            end
            // Data follows the grant that was active during the cycle just ending.
            case (r_state)
                S_OWN_A: begin
                    r_x       <= a;
                    r_x_valid <= 1'b1;
                end
                S_OWN_B: begin
                    r_x       <= b;
                    r_x_valid <= 1'b1;
                end
                default: begin
                    r_x_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a   = r_gnt_a;
    assign gnt_b   = r_gnt_b;
    assign sel     = r_sel;
    assign x       = r_x;
    assign x_valid = r_x_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_arbiter                                               |
// | Description : Randomised and directed bench for mux_arbiter against an     |
// |               ownership-level reference model (MUX_ARBITER_LOCK_EN aware). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mux_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
`ifdef MUX_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_a;
    logic             req_b;
    logic             lock_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] x;
    logic             x_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: who owns the line (0 none, 1 A, 2 B), who owned it last,
    // and how many contended cycles the current owner has already used.
    int               m_owner;
    int               m_last;
    int               m_used;
    logic [WIDTH-1:0] m_x;
    logic             m_xv;

    always #5 clk = ~clk;

    mux_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef MUX_ARBITER_LOCK_EN
        .lock    (lock_in),
`endif
        .req_a   (req_a),
        .req_b   (req_b),
        .a       (a),
        .b       (b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .sel     (sel),
        .x       (x),
        .x_valid (x_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit mine;
        bit other;
        bit lk;
        int want;
        if (!rst_n) begin
            m_owner = 0;
            m_last  = 2;
            m_used  = 0;
            m_x     = '0;
            m_xv    = 1'b0;
            return;
        end
        if (m_owner == 1) begin
            m_x = a; m_xv = 1'b1;
        end else if (m_owner == 2) begin
            m_x = b; m_xv = 1'b1;
        end else begin
            m_xv = 1'b0;
        end
        lk   = LOCK_EN && lock_in;
        want = m_owner;
        if (m_owner == 0) begin
            if (req_a && req_b) want = 3 - m_last;
            else if (req_a)     want = 1;
            else if (req_b)     want = 2;
        end else begin
            mine  = (m_owner == 1) ? req_a : req_b;
            other = (m_owner == 1) ? req_b : req_a;
            if (!mine) begin
                want = other ? 3 - m_owner : 0;
            end else if (other) begin
                m_used = m_used + 1;
                if (m_used >= MAX_BURST && !lk) want = 3 - m_owner;
                else if (m_used > MAX_BURST) m_used = MAX_BURST;
            end else begin
                m_used = 0;
            end
        end
        if (want != 0 && want != m_owner) begin
            m_last = want;
            m_used = 0;
        end
        m_owner = want;
    endtask

    task automatic compare_all();
        check("gnt_a",   {31'd0, gnt_a},   {31'd0, m_owner == 1});
        check("gnt_b",   {31'd0, gnt_b},   {31'd0, m_owner == 2});
        check("sel",     {31'd0, sel},     {31'd0, m_owner == 2});
        check("x",       {24'd0, x},       {24'd0, m_x});
        check("x_valid", {31'd0, x_valid}, {31'd0, m_xv});
        check("mutex",   {31'd0, gnt_a & gnt_b}, 32'd0);
    endtask

    // Drive inputs (called from the falling edge), take one rising edge, check.
    task automatic tick(input logic rn, input logic ra, input logic rb,
                        input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                        input logic lk);
        rst_n = rn; req_a = ra; req_b = rb; a = da; b = db; lock_in = lk;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [15:0] pattern;
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0; lock_in = 1'b0;
        m_owner = 0; m_last = 2; m_used = 0; m_x = '0; m_xv = 1'b0;
        @(negedge clk);

        // Reset with both requesting, then release: A wins the first tie.
        tick(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        check("rst_x", {24'd0, x}, 32'd0);
        tick(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        check("first_tie_a", {31'd0, gnt_a}, 32'd1);

        // Single requester A for 10 cycles.
        tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 8'h01, 8'hEE, 1'b0);
        check("single_x", {24'd0, x}, 32'd1);
        check("single_gnt", {31'd0, gnt_a}, 32'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h01, 8'hEE, 1'b0);
        check("single_idle", {30'd0, gnt_a, gnt_b}, 32'd0);

        // Contention from reset: AAAABBBBAAAABBBB.
        tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b1, 1'b1, 8'(i), 8'(8'h80 + i), 1'b0);
            pattern[15 - i] = gnt_a;
        end
        check("burst_pattern", {16'd0, pattern}, 32'h0000_F0F0);

        // Direct handoff from A to B without an idle bubble.
        tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b0);
        check("handoff_b", {30'd0, gnt_a, gnt_b}, 32'd1);

        // Mid-grant reset while B owns with two contended cycles used.
        tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
        check("pre_rst_b", {31'd0, gnt_b}, 32'd1);
        tick(1'b0, 1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
        check("midrst_all", {20'd0, gnt_a, gnt_b, sel, x_valid, x}, 32'd0);
        tick(1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
        check("midrst_then_a", {31'd0, gnt_a}, 32'd1);

`ifdef MUX_ARBITER_LOCK_EN
        // Locked contention keeps A; releasing the lock hands off at once.
        tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b1, 8'h77, 8'h88, 1'b1);
            check("lock_hold_a", {31'd0, gnt_a}, 32'd1);
        end
        tick(1'b1, 1'b1, 1'b1, 8'h77, 8'h88, 1'b0);
        check("unlock_b", {31'd0, gnt_b}, 32'd1);
`endif

        // Randomised traffic with sticky requests and occasional resets.
        begin
            logic ra;
            logic rb;
            logic lk;
            ra = 1'b0; rb = 1'b0; lk = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) ra = ~ra;
                if ($urandom_range(0, 3) == 0) rb = ~rb;
                if ($urandom_range(0, 5) == 0) lk = ~lk;
                tick(($urandom_range(0, 60) != 0), ra, rb,
                     8'($urandom), 8'($urandom), lk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
